// File: rtl/data_mem_responder.sv
// Load/store responder for the datapath: accepts one request per handshake,
// waits a fixed number of cycles, then answers with extended load data or
// commits a byte/half/word store. Flags misaligned, out-of-range and
// illegal-funct3 accesses.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;

    // Latched request
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;

    // Storage and its registered read port
    logic [31:0] mem [0:DEPTH_WORDS-1];
    logic [31:0] mem_rd_reg;

    // Response values held after the completion pulse
    logic [31:0] rdata_hold_reg;
    logic        err_hold_reg;

    logic             accept;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       size;
    logic             out_of_range;
    logic             legal_f3;
    logic             misalign;
    logic             err_now;
    logic [31:0]      byte_sel;
    logic [31:0]      half_sel;
    logic [31:0]      load_data;
    logic [31:0]      rdata_now;
    logic [31:0]      st_data;
    logic [3:0]       be;
    logic [31:0]      wr_word;
    logic             wr_en;

    assign req_ready = (state_reg == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign busy      = (state_reg != S_IDLE);
    assign rsp_valid = (state_reg == S_RESP) && !reset;

    // Next-state and wait-counter logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    cnt_next   = WAIT_INIT;
                    state_next = (WAIT_INIT == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_next == 4'd0) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Capture the request fields on the accepting edge
    always_ff @(posedge clk) begin
        if (accept) begin
            we_reg     <= req_we;
            funct3_reg <= req_funct3;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
        end
    end

    // Request decode and error detection
    always_comb begin
        word_idx     = addr_reg[IDX_W+1:2];
        size         = funct3_reg[1:0];
        out_of_range = |addr_reg[ADDR_W-1:IDX_W+2];
        if (we_reg) begin
            legal_f3 = !funct3_reg[2] && (size != 2'b11);
        end else begin
            legal_f3 = (size != 2'b11) && !(funct3_reg[2] && size == 2'b10);
        end
        misalign = ((size == 2'b01) && addr_reg[0]) ||
                   ((size == 2'b10) && (addr_reg[1:0] != 2'b00));
        err_now  = !legal_f3 || misalign || out_of_range;
    end

    // Load lane selection and extension
    always_comb begin
        byte_sel  = mem_rd_reg >> {addr_reg[1:0], 3'b000};
        half_sel  = mem_rd_reg >> {addr_reg[1], 4'b0000};
        load_data = 32'd0;
        case (funct3_reg)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel[7:0]};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel[15:0]};
            3'b010:  load_data = mem_rd_reg;
            3'b100:  load_data = {24'd0, byte_sel[7:0]};
            3'b101:  load_data = {16'd0, half_sel[15:0]};
            default: load_data = 32'd0;
        endcase
        rdata_now = (err_now || we_reg) ? 32'd0 : load_data;
    end

    // Store data replication and byte enables
    always_comb begin
        st_data = wdata_reg;
        be      = 4'b1111;
        case (size)
            2'b00: begin
                st_data = {4{wdata_reg[7:0]}};
                be      = 4'b0001 << addr_reg[1:0];
            end
            2'b01: begin
                st_data = {2{wdata_reg[15:0]}};
                be      = addr_reg[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = wdata_reg;
                be      = 4'b1111;
            end
        endcase
    end

    // Merge new lanes into the word read at accept time
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_word[8*gi +: 8] = be[gi] ? st_data[8*gi +: 8] : mem_rd_reg[8*gi +: 8];
        end
    endgenerate

    // The store lands on the edge that ends RESP, unless reset discards it
    assign wr_en = (state_reg == S_RESP) && we_reg && !err_now && !reset;

    // Storage: read on accept, write at end of response
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_rd_reg <= mem[req_addr[IDX_W+1:2]];
        end
        if (wr_en) begin
            mem[word_idx] <= wr_word;
        end
    end

    // Keep the last response visible after the pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_hold_reg <= 32'd0;
            err_hold_reg   <= 1'b0;
        end else if (state_reg == S_RESP) begin
            rdata_hold_reg <= rdata_now;
            err_hold_reg   <= err_now;
        end
    end

    assign rsp_rdata = rsp_valid ? rdata_now : rdata_hold_reg;
    assign rsp_err   = rsp_valid ? err_now   : err_hold_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed cases plus random traffic
// checked against a byte-array memory model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        r0_valid, r0_we;
    logic [2:0]  r0_funct3;
    logic [31:0] r0_addr, r0_wdata;
    logic        r0_ready, r0_rsp_valid, r0_rsp_err, r0_busy;
    logic [31:0] r0_rsp_rdata;

    int tests = 0;
    int fails = 0;

    logic [7:0] ref_mem [0:1023];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ADDR_W(32)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(r0_valid), .req_we(r0_we), .req_funct3(r0_funct3),
        .req_addr(r0_addr), .req_wdata(r0_wdata),
        .req_ready(r0_ready), .rsp_valid(r0_rsp_valid), .rsp_rdata(r0_rsp_rdata),
        .rsp_err(r0_rsp_err), .busy(r0_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a flat byte array, accesses as byte loops
    task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] d, output logic e);
        int  nb;
        logic legal;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        nb = (f3[1:0] == 2'b11) ? 4 : (1 << f3[1:0]);
        e  = !legal || ((addr % nb) != 0) || (addr >= 32'd1024);
        d  = 32'd0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[addr + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) d = d | (32'(ref_mem[addr + i]) << (8*i));
                if (!f3[2] && nb < 4 && d[8*nb-1]) d = d | (32'hFFFF_FFFF << (8*nb));
            end
        end
    endtask

    // One full transaction on the WAIT_CYCLES=2 instance
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag, output logic [31:0] got);
        logic [31:0] exp_d;
        logic        exp_e;
        int          n;
        ref_access(we, f3, addr, wd, exp_d, exp_e);
        @(negedge clk);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        // Inputs must be ignored while busy
        req_we = 1'($urandom_range(0, 1)); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        n = 1;
        while (n < 40) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (n == 1) check({tag, ".busy"}, 32'(busy), 32'd1);
            @(posedge clk);
            n++;
        end
        req_valid = 1'b0;
        got = rsp_rdata;
        check({tag, ".latency"}, 32'(n), 32'd3);
        check({tag, ".rdata"}, rsp_rdata, exp_d);
        check({tag, ".err"}, 32'(rsp_err), 32'(exp_e));
        @(negedge clk);
        check({tag, ".pulse"}, 32'(rsp_valid), 32'd0);
        check({tag, ".ready_again"}, 32'(req_ready), 32'd1);
        check({tag, ".hold"}, rsp_rdata, exp_d);
        $display("[TB] %s we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d", tag, we, f3, addr, wd, got, rsp_err);
    endtask

    // Store accepted, then reset asserted k cycles later
    task automatic abort_store(input logic [31:0] addr, input logic [31:0] wd, input int k, input string tag);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int j = 1; j <= k; j++) begin
            @(negedge clk);
            if (j == k) begin
                reset = 1'b1;
                #1;
                check({tag, ".ready_in_reset"}, 32'(req_ready), 32'd0);
            end
            check({tag, ".no_rsp"}, 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
        check({tag, ".idle_rsp"}, 32'(rsp_valid), 32'd0);
        $display("[TB] %s store addr=%h aborted after %0d cycles", tag, addr, k);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic        we;
        logic [2:0]  f3;
        logic        t0_we   [0:5];
        logic [2:0]  t0_f3   [0:5];
        logic [31:0] t0_addr [0:5];
        logic [31:0] t0_wd   [0:5];
        logic [31:0] t0_exp  [0:5];

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'd0; req_wdata = 32'd0;
        r0_valid = 1'b0; r0_we = 1'b0; r0_funct3 = 3'b0; r0_addr = 32'd0; r0_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.ready_low", 32'(req_ready), 32'd0);
        check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        #1;
        check("reset.ready", 32'(req_ready), 32'd1);
        check("reset.rdata", rsp_rdata, 32'd0);
        check("reset.err", 32'(rsp_err), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);

        // Give every word a known value
        for (int w = 0; w < 256; w++) do_req(1'b1, 3'b010, 32'(w * 4), $urandom, "preload", got);

        // Word store/load
        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, "sw_10", got);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, "lw_10", got);
        check("lw_10.const", got, 32'hDEAD_BEEF);

        // Sub-word loads
        do_req(1'b0, 3'b000, 32'h13, 32'd0, "lb_13", got);
        check("lb_13.const", got, 32'hFFFF_FFDE);
        do_req(1'b0, 3'b100, 32'h13, 32'd0, "lbu_13", got);
        check("lbu_13.const", got, 32'h0000_00DE);
        do_req(1'b0, 3'b001, 32'h12, 32'd0, "lh_12", got);
        check("lh_12.const", got, 32'hFFFF_DEAD);
        do_req(1'b0, 3'b101, 32'h10, 32'd0, "lhu_10", got);
        check("lhu_10.const", got, 32'h0000_BEEF);

        // Sub-word stores preserve other lanes
        do_req(1'b1, 3'b000, 32'h11, 32'h1234_5677, "sb_11", got);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, "lw_after_sb", got);
        check("lw_after_sb.const", got, 32'hDEAD_77EF);
        do_req(1'b1, 3'b001, 32'h12, 32'h0000_CAFE, "sh_12", got);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, "lw_after_sh", got);
        check("lw_after_sh.const", got, 32'hCAFE_77EF);

        // Error cases
        do_req(1'b0, 3'b010, 32'h12, 32'd0, "lw_mis", got);
        do_req(1'b1, 3'b010, 32'h400, 32'h5555_AAAA, "sw_oor", got);
        do_req(1'b0, 3'b010, 32'h0, 32'd0, "lw_0_after_oor", got);
        do_req(1'b0, 3'b011, 32'h10, 32'd0, "ld_f3_011", got);
        do_req(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, "st_f3_100", got);
        do_req(1'b1, 3'b001, 32'h11, 32'hBBBB_BBBB, "sh_mis", got);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, "lw_after_sh_mis", got);
        check("lw_after_sh_mis.const", got, 32'hCAFE_77EF);

        // Reset during WAIT and during RESP discards the store
        abort_store(32'h20, 32'h1111_1111, 1, "abort_wait");
        do_req(1'b0, 3'b010, 32'h20, 32'd0, "lw_20", got);
        abort_store(32'h24, 32'h2222_2222, 3, "abort_resp");
        do_req(1'b0, 3'b010, 32'h24, 32'd0, "lw_24", got);

        // Random traffic against the model
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                else if (f3[1:0] != 2'b00) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 15) == 0) a = a | (32'h400 << $urandom_range(0, 21));
            do_req(we, f3, a, $urandom, $sformatf("rand%0d", i), got);
        end

        // Zero wait states, request held valid back to back
        t0_we[0] = 1'b1; t0_f3[0] = 3'b010; t0_addr[0] = 32'h0; t0_wd[0] = 32'h8BAD_F00D; t0_exp[0] = 32'h0;
        t0_we[1] = 1'b1; t0_f3[1] = 3'b010; t0_addr[1] = 32'h4; t0_wd[1] = 32'h12C4_FE80; t0_exp[1] = 32'h0;
        t0_we[2] = 1'b0; t0_f3[2] = 3'b010; t0_addr[2] = 32'h0; t0_wd[2] = 32'h0;         t0_exp[2] = 32'h8BAD_F00D;
        t0_we[3] = 1'b0; t0_f3[3] = 3'b010; t0_addr[3] = 32'h4; t0_wd[3] = 32'h0;         t0_exp[3] = 32'h12C4_FE80;
        t0_we[4] = 1'b0; t0_f3[4] = 3'b100; t0_addr[4] = 32'h5; t0_wd[4] = 32'h0;         t0_exp[4] = 32'h0000_00FE;
        t0_we[5] = 1'b0; t0_f3[5] = 3'b001; t0_addr[5] = 32'h2; t0_wd[5] = 32'h0;         t0_exp[5] = 32'hFFFF_8BAD;
        @(negedge clk);
        r0_valid = 1'b1; r0_we = t0_we[0]; r0_funct3 = t0_f3[0]; r0_addr = t0_addr[0]; r0_wdata = t0_wd[0];
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            if (c % 2 == 0) begin
                check($sformatf("w0.c%0d.ready", c), 32'(r0_ready), 32'd1);
                check($sformatf("w0.c%0d.busy", c), 32'(r0_busy), 32'd0);
                check($sformatf("w0.c%0d.rsp", c), 32'(r0_rsp_valid), 32'd0);
            end else begin
                check($sformatf("w0.c%0d.rsp", c), 32'(r0_rsp_valid), 32'd1);
                check($sformatf("w0.c%0d.busy", c), 32'(r0_busy), 32'd1);
                check($sformatf("w0.c%0d.rdata", c), r0_rsp_rdata, t0_exp[c/2]);
                check($sformatf("w0.c%0d.err", c), 32'(r0_rsp_err), 32'd0);
                $display("[TB] w0 req%0d addr=%h -> rdata=%h", c/2, t0_addr[c/2], r0_rsp_rdata);
                if (c/2 + 1 < 6) begin
                    r0_we = t0_we[c/2+1]; r0_funct3 = t0_f3[c/2+1];
                    r0_addr = t0_addr[c/2+1]; r0_wdata = t0_wd[c/2+1];
                end else begin
                    r0_valid = 1'b0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
